telemetry_tx_sequencer: RTL

//  Transmit-side counterpart of the command interpreter: on a telemetry request code ('p','r','d','b','m')
//  it snapshots the matching sensor words and streams one framed reply, byte by byte, into the UART TX.

---
 rtl/telemetry_tx_sequencer_pkg.sv | 42 ++++
 rtl/telemetry_payload_snapshot.sv | 48 ++++
 rtl/telemetry_tx_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/telemetry_tx_sequencer_pkg.sv
// Shared request codes, payload lengths and FSM encoding for the telemetry transmit path.
// The command interpreter decodes the same request codes.
package telemetry_tx_sequencer_pkg;

  localparam int INT_WIDTH   = 8;
  localparam int N_WIDTH     = 32;
  localparam int MAX_PAYLOAD = 16;
  localparam int IDX_WIDTH   = 5;

  localparam logic [INT_WIDTH-1:0] REQ_POSE     = 8'h70;  // 'p'
  localparam logic [INT_WIDTH-1:0] REQ_RPM      = 8'h72;  // 'r'
  localparam logic [INT_WIDTH-1:0] REQ_DIST     = 8'h64;  // 'd'
  localparam logic [INT_WIDTH-1:0] REQ_BEHAVIOR = 8'h62;  // 'b'
  localparam logic [INT_WIDTH-1:0] REQ_IMU      = 8'h6D;  // 'm'

  localparam logic [IDX_WIDTH-1:0] LEN_POSE     = 5'd12;
  localparam logic [IDX_WIDTH-1:0] LEN_RPM      = 5'd4;
  localparam logic [IDX_WIDTH-1:0] LEN_DIST     = 5'd16;
  localparam logic [IDX_WIDTH-1:0] LEN_BEHAVIOR = 5'd1;
  localparam logic [IDX_WIDTH-1:0] LEN_IMU      = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECKSUM
  } txState_t;

  // A length of zero marks an unknown request code.
  function automatic logic [IDX_WIDTH-1:0] payloadLen(input logic [INT_WIDTH-1:0] code);
    case (code)
      REQ_POSE:     return LEN_POSE;
      REQ_RPM:      return LEN_RPM;
      REQ_DIST:     return LEN_DIST;
      REQ_BEHAVIOR: return LEN_BEHAVIOR;
      REQ_IMU:      return LEN_IMU;
      default:      return '0;
    endcase
  endfunction

endpackage

// File: rtl/telemetry_payload_snapshot.sv
// Captures the sensor words selected by a request code into a byte buffer, MSB first,
// and serves one byte by index so the frame stays coherent while sensors keep changing.
module telemetry_payload_snapshot
  import telemetry_tx_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 load,
  input  logic [INT_WIDTH-1:0] code,
  input  logic [N_WIDTH-1:0]   posX,
  input  logic [N_WIDTH-1:0]   posY,
  input  logic [N_WIDTH-1:0]   theta,
  input  logic [INT_WIDTH-1:0] rpm1,
  input  logic [INT_WIDTH-1:0] rpm2,
  input  logic [INT_WIDTH-1:0] rpm3,
  input  logic [INT_WIDTH-1:0] rpm4,
  input  logic [N_WIDTH-1:0]   dist1,
  input  logic [N_WIDTH-1:0]   dist2,
  input  logic [N_WIDTH-1:0]   dist3,
  input  logic [N_WIDTH-1:0]   dist4,
  input  logic [INT_WIDTH-1:0] behavior,
  input  logic [N_WIDTH-1:0]   imuX,
  input  logic [N_WIDTH-1:0]   imuY,
  input  logic [N_WIDTH-1:0]   imuZ,
  input  logic [3:0]           readIdx,
  output logic [INT_WIDTH-1:0] readByte
);

  // Byte 0 of the payload sits in the most significant byte of snapReg.
  logic [MAX_PAYLOAD*INT_WIDTH-1:0] snapReg;
  logic [3:0]                       bytePos;

  always_ff @(posedge clk) begin
    if (load) begin
      case (code)
        REQ_POSE:     snapReg <= {posX, posY, theta, 32'h0};
        REQ_RPM:      snapReg <= {rpm1, rpm2, rpm3, rpm4, 96'h0};
        REQ_DIST:     snapReg <= {dist1, dist2, dist3, dist4};
        REQ_BEHAVIOR: snapReg <= {behavior, 120'h0};
        REQ_IMU:      snapReg <= {imuX, imuY, imuZ, 32'h0};
        default:      snapReg <= '0;
      endcase
    end
  end

  assign bytePos  = 4'(MAX_PAYLOAD - 1) - readIdx;
  assign readByte = snapReg[{bytePos, 3'b000} +: INT_WIDTH];

endmodule

// File: rtl/telemetry_tx_sequencer.sv
// Streams one framed telemetry reply (header, snapshot payload, 8-bit sum) into the UART TX.
// TX handshake: a byte moves on a clock edge with TXVALID=1 and TXREADY=1; TXVALID/TXDATA hold otherwise.
module telemetry_tx_sequencer
  import telemetry_tx_sequencer_pkg::*;
(
  input  logic                 TELEMETRY_TX_SEQUENCER_CLOCK_50,
  input  logic                 TELEMETRY_TX_SEQUENCER_RESET_InLow,
  input  logic                 TELEMETRY_TX_SEQUENCER_REQVALID_In,
  input  logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_REQCODE_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_POSX_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_POSY_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_THETA_InBus,
  input  logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_RPM1_InBus,
  input  logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_RPM2_InBus,
  input  logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_RPM3_InBus,
  input  logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_RPM4_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_DIST1_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_DIST2_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_DIST3_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_DIST4_InBus,
  input  logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_BEHAVIOR_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_IMUX_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_IMUY_InBus,
  input  logic [N_WIDTH-1:0]   TELEMETRY_TX_SEQUENCER_IMUZ_InBus,
  input  logic                 TELEMETRY_TX_SEQUENCER_TXREADY_In,
  output logic                 TELEMETRY_TX_SEQUENCER_TXVALID_Out,
  output logic [INT_WIDTH-1:0] TELEMETRY_TX_SEQUENCER_TXDATA_OutBus,
  output logic                 TELEMETRY_TX_SEQUENCER_BUSY_Out,
  output logic                 TELEMETRY_TX_SEQUENCER_DONE_Out,
  output logic                 TELEMETRY_TX_SEQUENCER_OVERRUN_Out,
  output txState_t             TELEMETRY_TX_SEQUENCER_STATE_OutBus
);

  txState_t             state, stateNext;
  logic [INT_WIDTH-1:0] codeReg, codeNext;
  logic [IDX_WIDTH-1:0] lenReg, lenNext;
  logic [IDX_WIDTH-1:0] idx, idxNext;
  logic [INT_WIDTH-1:0] checksum, checksumNext;
  logic [INT_WIDTH-1:0] txData, txDataNext;
  logic                 txValid, txValidNext;
  logic                 done, doneNext;
  logic                 overrun, overrunNext;
  logic                 knownReq, handshake, loadSnapshot;
  logic [3:0]           readIdx;
  logic [INT_WIDTH-1:0] readByte;
  logic [INT_WIDTH-1:0] sumWithByte;

  assign knownReq    = TELEMETRY_TX_SEQUENCER_REQVALID_In
                       && (payloadLen(TELEMETRY_TX_SEQUENCER_REQCODE_InBus) != '0);
  assign handshake   = txValid && TELEMETRY_TX_SEQUENCER_TXREADY_In;
  assign sumWithByte = checksum + txData;
  // TXDATA is registered, so the buffer is read one byte ahead of the byte on the wire.
  assign readIdx     = (state == ST_PAYLOAD) ? (idx[3:0] + 4'd1) : idx[3:0];

  telemetry_payload_snapshot uSnapshot (
    .clk      (TELEMETRY_TX_SEQUENCER_CLOCK_50),
    .load     (loadSnapshot),
    .code     (TELEMETRY_TX_SEQUENCER_REQCODE_InBus),
    .posX     (TELEMETRY_TX_SEQUENCER_POSX_InBus),
    .posY     (TELEMETRY_TX_SEQUENCER_POSY_InBus),
    .theta    (TELEMETRY_TX_SEQUENCER_THETA_InBus),
    .rpm1     (TELEMETRY_TX_SEQUENCER_RPM1_InBus),
    .rpm2     (TELEMETRY_TX_SEQUENCER_RPM2_InBus),
    .rpm3     (TELEMETRY_TX_SEQUENCER_RPM3_InBus),
    .rpm4     (TELEMETRY_TX_SEQUENCER_RPM4_InBus),
    .dist1    (TELEMETRY_TX_SEQUENCER_DIST1_InBus),
    .dist2    (TELEMETRY_TX_SEQUENCER_DIST2_InBus),
    .dist3    (TELEMETRY_TX_SEQUENCER_DIST3_InBus),
    .dist4    (TELEMETRY_TX_SEQUENCER_DIST4_InBus),
    .behavior (TELEMETRY_TX_SEQUENCER_BEHAVIOR_InBus),
    .imuX     (TELEMETRY_TX_SEQUENCER_IMUX_InBus),
    .imuY     (TELEMETRY_TX_SEQUENCER_IMUY_InBus),
    .imuZ     (TELEMETRY_TX_SEQUENCER_IMUZ_InBus),
    .readIdx  (readIdx),
    .readByte (readByte)
  );

  always_comb begin
    stateNext    = state;
    codeNext     = codeReg;
    lenNext      = lenReg;
    idxNext      = idx;
    checksumNext = checksum;
    txDataNext   = txData;
    txValidNext  = txValid;
    doneNext     = 1'b0;
    overrunNext  = overrun;
    loadSnapshot = 1'b0;

    if (knownReq && (state != ST_IDLE)) overrunNext = 1'b1;

    case (state)
      ST_IDLE: begin
        if (knownReq) begin
          stateNext    = ST_LOAD;
          codeNext     = TELEMETRY_TX_SEQUENCER_REQCODE_InBus;
          lenNext      = payloadLen(TELEMETRY_TX_SEQUENCER_REQCODE_InBus);
          loadSnapshot = 1'b1;
        end
      end
      ST_LOAD: begin
        txDataNext   = codeReg;
        txValidNext  = 1'b1;
        checksumNext = codeReg;
        idxNext      = '0;
        stateNext    = ST_HEADER;
      end
      ST_HEADER: begin
        if (handshake) begin
          txDataNext = readByte;
          stateNext  = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (handshake) begin
          checksumNext = sumWithByte;
          if (idx == lenReg - 5'd1) begin
            txDataNext = sumWithByte;
            stateNext  = ST_CHECKSUM;
          end else begin
            idxNext    = idx + 5'd1;
            txDataNext = readByte;
          end
        end
      end
      ST_CHECKSUM: begin
        if (handshake) begin
          txValidNext = 1'b0;
          doneNext    = 1'b1;
          stateNext   = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge TELEMETRY_TX_SEQUENCER_CLOCK_50) begin
    if (!TELEMETRY_TX_SEQUENCER_RESET_InLow) begin
      state    <= ST_IDLE;
      codeReg  <= '0;
      lenReg   <= '0;
      idx      <= '0;
      checksum <= '0;
      txData   <= '0;
      txValid  <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= stateNext;
      codeReg  <= codeNext;
      lenReg   <= lenNext;
      idx      <= idxNext;
      checksum <= checksumNext;
      txData   <= txDataNext;
      txValid  <= txValidNext;
      done     <= doneNext;
      overrun  <= overrunNext;
    end
  end

  assign TELEMETRY_TX_SEQUENCER_TXVALID_Out   = txValid;
  assign TELEMETRY_TX_SEQUENCER_TXDATA_OutBus = txData;
  assign TELEMETRY_TX_SEQUENCER_BUSY_Out      = (state != ST_IDLE);
  assign TELEMETRY_TX_SEQUENCER_DONE_Out      = done;
  assign TELEMETRY_TX_SEQUENCER_OVERRUN_Out   = overrun;
  assign TELEMETRY_TX_SEQUENCER_STATE_OutBus  = state;

endmodule
